// File: rtl/spi_cfg_sequencer.sv
// SPI configuration sequencer: walks NUM_DEV configuration engines in index order and muxes their SPI requests onto one master.
// Define SPI_CFG_TIMEOUT_EN to build the per-device RUN timeout (default build: no timeout, o_dev_err tied to 0).
module spi_cfg_sequencer #(
   parameter int NUM_DEV         = 3,
   parameter int MOSI_DATA_WIDTH = 24,
   parameter int TIMEOUT_CYCLES  = 1048576
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               i_cfg_start,
   input  logic [NUM_DEV-1:0]                 i_dev_skip,
   output logic [NUM_DEV-1:0]                 o_dev_start,
   input  logic [NUM_DEV-1:0]                 i_dev_done,
   input  logic [NUM_DEV-1:0]                 i_dev_wr_cmd,
   input  logic [NUM_DEV-1:0]                 i_dev_rd_cmd,
   input  logic [NUM_DEV*MOSI_DATA_WIDTH-1:0] i_dev_wr_data,
   output logic                               o_spi_wr_cmd,
   output logic                               o_spi_rd_cmd,
   output logic [MOSI_DATA_WIDTH-1:0]         o_spi_wr_data,
   input  logic                               i_spi_busy,
   input  logic                               i_spi_ncs,
   output logic [NUM_DEV-1:0]                 o_dev_cs_n,
   output logic [2:0]                         o_cur_dev,
   output logic                               o_busy,
   output logic                               o_cfg_done,
   output logic [NUM_DEV-1:0]                 o_dev_ok,
   output logic [NUM_DEV-1:0]                 o_dev_err
);

   // state  | meaning
   // IDLE   | waiting for a start edge
   // SELECT | examine device cur; skip it or launch its engine
   // RUN    | engine cur owns the SPI master until done (or timeout)
   // DRAIN  | wait for the SPI master to go idle before moving on
   // DONE   | one-cycle completion pulse
   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [2:0] LAST_DEV = 3'(NUM_DEV - 1);

   if (NUM_DEV < 1 || NUM_DEV > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("spi_cfg_sequencer: NUM_DEV must be 1..8 and TIMEOUT_CYCLES >= 1");
   end

   state_t                     state_q, state_d;
   logic [2:0]                 cur_q, cur_d;
   logic                       cfg_start_q, cfg_start_prev_q;
   logic [NUM_DEV-1:0]         dev_ok_q, dev_ok_d;
   logic [NUM_DEV-1:0]         cur_sel;
   logic [MOSI_DATA_WIDTH-1:0] wr_data_cur;
   logic                       start, skip_cur, done_cur, last_dev;

`ifdef SPI_CFG_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [NUM_DEV-1:0] dev_err_q, dev_err_d;
   logic               tmo_hit;

   assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
   assign o_dev_err = dev_err_q;
`else
   assign o_dev_err = '0;
`endif

   // Edge detect on the registered request so a held-high start fires once.
   assign start    = cfg_start_q & ~cfg_start_prev_q;
   assign last_dev = (cur_q == LAST_DEV);
   assign skip_cur = |(i_dev_skip & cur_sel);
   assign done_cur = |(i_dev_done & cur_sel);

   assign o_cur_dev = cur_q;
   assign o_dev_ok  = dev_ok_q;

   always_comb begin
      cur_sel     = '0;
      wr_data_cur = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         cur_sel[i] = (cur_q == 3'(i));
         if (cur_q == 3'(i)) begin
            wr_data_cur = i_dev_wr_data[i*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      dev_ok_d      = dev_ok_q;
`ifdef SPI_CFG_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      dev_err_d     = dev_err_q;
`endif
      o_busy        = 1'b0;
      o_cfg_done    = 1'b0;
      o_dev_start   = '0;
      o_spi_wr_cmd  = 1'b0;
      o_spi_rd_cmd  = 1'b0;
      o_spi_wr_data = '0;
      o_dev_cs_n    = '1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_d    = '0;
               dev_ok_d = '0;
`ifdef SPI_CFG_TIMEOUT_EN
               dev_err_d = '0;
`endif
               state_d  = S_SELECT;
            end
         end
         S_SELECT: begin
            o_busy = 1'b1;
            if (skip_cur) begin
               if (last_dev) state_d = S_DONE;
               else          cur_d   = cur_q + 3'd1;
            end else begin
`ifdef SPI_CFG_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            o_busy        = 1'b1;
            o_dev_start   = cur_sel;
            o_spi_wr_cmd  = |(i_dev_wr_cmd & cur_sel);
            o_spi_rd_cmd  = |(i_dev_rd_cmd & cur_sel);
            o_spi_wr_data = wr_data_cur;
            o_dev_cs_n    = ~cur_sel | {NUM_DEV{i_spi_ncs}};
            if (done_cur) begin
               dev_ok_d = dev_ok_q | cur_sel;
               state_d  = S_DRAIN;
            end
`ifdef SPI_CFG_TIMEOUT_EN
            else if (tmo_hit) begin
               dev_err_d = dev_err_q | cur_sel;
               state_d   = S_DRAIN;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
`endif
         end
         S_DRAIN: begin
            o_busy     = 1'b1;
            o_dev_cs_n = ~cur_sel | {NUM_DEV{i_spi_ncs}};
            if (!i_spi_busy) begin
               if (last_dev) begin
                  state_d = S_DONE;
               end else begin
                  cur_d   = cur_q + 3'd1;
                  state_d = S_SELECT;
               end
            end
         end
         S_DONE: begin
            o_cfg_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q          <= S_IDLE;
         cur_q            <= '0;
         cfg_start_q      <= 1'b0;
         cfg_start_prev_q <= 1'b0;
         dev_ok_q         <= '0;
`ifdef SPI_CFG_TIMEOUT_EN
         tmo_cnt_q        <= '0;
         dev_err_q        <= '0;
`endif
      end else begin
         state_q          <= state_d;
         cur_q            <= cur_d;
         cfg_start_q      <= i_cfg_start;
         cfg_start_prev_q <= cfg_start_q;
         dev_ok_q         <= dev_ok_d;
`ifdef SPI_CFG_TIMEOUT_EN
         tmo_cnt_q        <= tmo_cnt_d;
         dev_err_q        <= dev_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Self-checking bench for spi_cfg_sequencer: behavioural engines/SPI stub plus a per-sequence
// timing/order model; exercises the timeout path too when SPI_CFG_TIMEOUT_EN is defined.
module tb_spi_cfg_sequencer;
   localparam int N = 3;
   localparam int W = 24;
   localparam int T = 100;

   logic           clk = 1'b0;
   logic           nrst = 1'b0;
   logic           i_cfg_start = 1'b0;
   logic [N-1:0]   i_dev_skip = '0;
   logic [N-1:0]   o_dev_start;
   logic [N-1:0]   i_dev_done = '0;
   logic [N-1:0]   i_dev_wr_cmd = '0;
   logic [N-1:0]   i_dev_rd_cmd = '0;
   logic [N*W-1:0] i_dev_wr_data = '0;
   logic           o_spi_wr_cmd;
   logic           o_spi_rd_cmd;
   logic [W-1:0]   o_spi_wr_data;
   logic           i_spi_busy = 1'b0;
   logic           i_spi_ncs = 1'b1;
   logic [N-1:0]   o_dev_cs_n;
   logic [2:0]     o_cur_dev;
   logic           o_busy;
   logic           o_cfg_done;
   logic [N-1:0]   o_dev_ok;
   logic [N-1:0]   o_dev_err;

   spi_cfg_sequencer #(.NUM_DEV(N), .MOSI_DATA_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .nrst(nrst), .i_cfg_start(i_cfg_start), .i_dev_skip(i_dev_skip),
      .o_dev_start(o_dev_start), .i_dev_done(i_dev_done), .i_dev_wr_cmd(i_dev_wr_cmd),
      .i_dev_rd_cmd(i_dev_rd_cmd), .i_dev_wr_data(i_dev_wr_data), .o_spi_wr_cmd(o_spi_wr_cmd),
      .o_spi_rd_cmd(o_spi_rd_cmd), .o_spi_wr_data(o_spi_wr_data), .i_spi_busy(i_spi_busy),
      .i_spi_ncs(i_spi_ncs), .o_dev_cs_n(o_dev_cs_n), .o_cur_dev(o_cur_dev), .o_busy(o_busy),
      .o_cfg_done(o_cfg_done), .o_dev_ok(o_dev_ok), .o_dev_err(o_dev_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Engine settings: lat = cycles from start to done (0 = never), bsy = SPI busy cycles after done.
   int           lat [N];
   int           bsy [N];
   bit           noise_en = 1'b0;
   int           active = -1;
   int           run_cnt = 0;
   int           busy_left = 0;
   int           got_q [$];
   int           done_cnt = 0;
   int           done_cyc = 0;
   logic [N-1:0] cs_low = '0;

   // Output checks first (inputs still stable), then the engines drive the next cycle's inputs.
   always @(negedge clk) begin : engines
      int           idx;
      logic [N-1:0] cur_mask;
      logic [N-1:0] drv_done;
      if (!nrst) begin
         active     = -1;
         busy_left  = 0;
         i_dev_done = '0;
         i_spi_busy = 1'b0;
      end else begin
         idx      = -1;
         cur_mask = '0;
         for (int i = 0; i < N; i++) begin
            if (o_dev_start[i]) idx = i;
            if (o_cur_dev == 3'(i)) cur_mask[i] = 1'b1;
         end
         chk("start_onehot", 64'($countones(o_dev_start) <= 1), 64'd1);
         chk("cs_non_cur_high", o_dev_cs_n | cur_mask, {N{1'b1}});
         if (idx >= 0) begin
            chk("cur_dev", o_cur_dev, idx);
            chk("mux_wr_cmd", o_spi_wr_cmd, i_dev_wr_cmd[idx]);
            chk("mux_rd_cmd", o_spi_rd_cmd, i_dev_rd_cmd[idx]);
            chk("mux_wr_data", o_spi_wr_data, i_dev_wr_data[idx*W +: W]);
            chk("cs_follows_ncs", o_dev_cs_n[idx], i_spi_ncs);
         end else begin
            chk("mux_quiet", {o_spi_wr_cmd, o_spi_rd_cmd, o_spi_wr_data}, 64'd0);
         end
         if (!o_busy) chk("cs_idle", o_dev_cs_n, {N{1'b1}});
         if (o_cfg_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         cs_low = cs_low | ~o_dev_cs_n;

         if (busy_left > 0) busy_left--;
         if (active >= 0 && idx != active) active = -1;
         if (active < 0) begin
            if (idx >= 0) begin
               active  = idx;
               run_cnt = 0;
               got_q.push_back(idx);
            end
         end else begin
            run_cnt++;
         end
         drv_done = noise_en ? N'($urandom) : '0;
         if (active >= 0) begin
            drv_done[active] = (lat[active] > 0) && (run_cnt >= lat[active] - 1);
            if (lat[active] > 0 && run_cnt == lat[active] - 1) busy_left = bsy[active];
         end
         i_dev_done   = drv_done;
         i_spi_busy   = (busy_left > 0);
         i_spi_ncs    = 1'($urandom_range(0, 1));
         i_dev_wr_cmd = N'($urandom);
         i_dev_rd_cmd = N'($urandom);
         for (int i = 0; i < N; i++) i_dev_wr_data[i*W +: W] = W'($urandom);
      end
   end

   // Model: one cycle per skipped index; otherwise SELECT + RUN + DRAIN. The pulse lands two
   // cycles after the edge-detect/IDLE hop following the cycle start was driven.
   task automatic run_seq(input string name, input logic [N-1:0] skip, input bit pulse_again);
      int           exp_q [$];
      logic [N-1:0] exp_ok, exp_err;
      int           total, runlen, drain, drv, k;
      bit           tmo;
      total   = 0;
      exp_ok  = '0;
      exp_err = '0;
      for (int i = 0; i < N; i++) begin
         if (skip[i]) begin
            total += 1;
         end else begin
            exp_q.push_back(i);
`ifdef SPI_CFG_TIMEOUT_EN
            tmo = (lat[i] == 0) || (lat[i] > T);
`else
            tmo = 1'b0;
`endif
            if (tmo) begin
               runlen     = T;
               drain      = 1;
               exp_err[i] = 1'b1;
            end else begin
               runlen    = lat[i];
               drain     = (bsy[i] > 1) ? bsy[i] : 1;
               exp_ok[i] = 1'b1;
            end
            total += 1 + runlen + drain;
         end
      end

      @(negedge clk);
      got_q.delete();
      done_cnt    = 0;
      cs_low      = '0;
      i_dev_skip  = skip;
      i_cfg_start = 1'b1;
      drv         = cyc;
      k           = 0;
      while (done_cnt == 0 && k < total + 40) begin
         @(negedge clk);
         k++;
         if (k == 2) i_cfg_start = 1'b0;
         if (pulse_again && total >= 10 && k == 6) i_cfg_start = 1'b1;
         if (pulse_again && total >= 10 && k == 7) i_cfg_start = 1'b0;
      end
      chk({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
      repeat (12) @(negedge clk);
      chk({name, "_one_pulse"}, done_cnt, 1);
      chk({name, "_idle_after"}, o_busy, 1'b0);
      chk({name, "_done_cycle"}, done_cyc, drv + 2 + total);
      chk({name, "_dev_ok"}, o_dev_ok, exp_ok);
      chk({name, "_dev_err"}, o_dev_err, exp_err);
      chk({name, "_skip_cs_high"}, cs_low & skip, 64'd0);
      chk({name, "_order_len"}, got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size(); j++) begin
         chk({name, "_order"}, (j < got_q.size()) ? got_q[j] : -1, exp_q[j]);
      end
   endtask

   task automatic set_all(input int l, input int b);
      for (int i = 0; i < N; i++) begin
         lat[i] = l;
         bsy[i] = b;
      end
   endtask

   task automatic reset_mid_run;
      int k;
      set_all(40, 0);
      noise_en = 1'b1;
      @(negedge clk);
      done_cnt    = 0;
      i_dev_skip  = '0;
      i_cfg_start = 1'b1;
      k = 0;
      while (o_dev_start !== 3'b010 && k < 300) begin
         @(negedge clk);
         k++;
         if (k == 2) i_cfg_start = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_reached_dev1", o_dev_start, 3'b010);
      i_cfg_start = 1'b1;
      @(negedge clk);
      i_cfg_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_start_ignored", o_dev_start, 3'b010);
      chk("busy_start_cur", o_cur_dev, 3'd1);
      chk("busy_start_ok", o_dev_ok, 3'b001);
      #2 nrst = 1'b0;
      #1;
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_cs_n", o_dev_cs_n, 3'b111);
      chk("rst_dev_start", o_dev_start, 3'b000);
      chk("rst_cur", o_cur_dev, 3'd0);
      chk("rst_ok", o_dev_ok, 3'b000);
      chk("rst_err", o_dev_err, 3'b000);
      chk("rst_done", o_cfg_done, 1'b0);
      @(negedge clk);
      nrst     = 1'b1;
      done_cnt = 0;
      repeat (20) @(negedge clk);
      chk("rst_no_done_pulse", done_cnt, 0);
      chk("rst_stays_idle", o_busy, 1'b0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      set_all(50, 0);
      #12;
      chk("reset_busy", o_busy, 1'b0);
      chk("reset_cs_n", o_dev_cs_n, 3'b111);
      chk("reset_done", o_cfg_done, 1'b0);
      chk("reset_ok_err", {o_dev_ok, o_dev_err}, 6'b0);
      chk("reset_cur", o_cur_dev, 3'd0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(negedge clk);

      run_seq("all_run", 3'b000, 1'b0);
      run_seq("skip0", 3'b001, 1'b0);
      run_seq("skip_all", 3'b111, 1'b0);
      set_all(10, 20);
      noise_en = 1'b1;
      run_seq("busy_hold", 3'b000, 1'b1);
`ifdef SPI_CFG_TIMEOUT_EN
      set_all(50, 2);
      lat[0] = T;
      lat[1] = 0;
      run_seq("timeout_dev1", 3'b000, 1'b1);
`endif
      for (int s = 0; s < 10; s++) begin
         for (int i = 0; i < N; i++) begin
            lat[i] = $urandom_range(1, 60);
            bsy[i] = $urandom_range(0, 4);
`ifdef SPI_CFG_TIMEOUT_EN
            if ($urandom_range(0, 4) == 0) lat[i] = 0;
`endif
         end
         run_seq("random", N'($urandom), 1'b1);
      end
      reset_mid_run();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_cfg_sequencer.md
SPI_CFG_SEQUENCER -- requirements
Module: spi_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_DEV, default 3: number of SPI target devices (1..8).
REQ-002 SHALL have parameter MOSI_DATA_WIDTH, default 24: SPI write word width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576: per-device configuration timeout, in clk cycles.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock
- nrst  in  1  reset, asynchronous, active-low
- i_cfg_start  in  1  start request, rising-edge detected
- i_dev_skip  in  NUM_DEV  bit i set: device i is skipped (e.g. clock chip already locked)
- o_dev_start  out  NUM_DEV  level enable to device i's configuration engine
- i_dev_done  in  NUM_DEV  done from device i's engine
- i_dev_wr_cmd  in  NUM_DEV  per-device SPI write request
- i_dev_rd_cmd  in  NUM_DEV  per-device SPI read request
- i_dev_wr_data  in  NUM_DEV*MOSI_DATA_WIDTH  per-device write word; slice i = bits [i*W +: W]
- o_spi_wr_cmd  out  1  muxed write command to SPI master
- o_spi_rd_cmd  out  1  muxed read command to SPI master
- o_spi_wr_data  out  MOSI_DATA_WIDTH  muxed write word
- i_spi_busy  in  1  SPI master busy
- i_spi_ncs  in  1  SPI master chip select
- o_dev_cs_n  out  NUM_DEV  per-device chip selects
- o_cur_dev  out  3  index of active device
- o_busy  out  1  sequence in progress
- o_cfg_done  out  1  one-cycle pulse at sequence end
- o_dev_ok  out  NUM_DEV  sticky: device i completed
- o_dev_err  out  NUM_DEV  sticky: device i timed out

Function
REQ-005 SHALL register i_cfg_start and form start = i_cfg_start & ~previous value; the FSM SHALL leave IDLE on the cycle after start is high.
REQ-006 SHALL implement FSM states IDLE, SELECT, RUN, DRAIN, DONE.
REQ-007 IDLE: on start, SHALL set cur=0, clear o_dev_ok and o_dev_err, and go to SELECT; o_busy=0.
REQ-008 SELECT: if i_dev_skip[cur]=1, SHALL increment cur, or go to DONE when cur=NUM_DEV-1; otherwise SHALL go to RUN. One cycle is spent per index examined.
REQ-009 RUN: o_dev_start[cur]=1, all other o_dev_start bits 0; o_spi_wr_cmd, o_spi_rd_cmd and o_spi_wr_data SHALL combinationally follow device cur.
REQ-010 RUN: on i_dev_done[cur], SHALL set o_dev_ok[cur] and go to DRAIN.
REQ-011 DRAIN: SHALL wait until i_spi_busy=0, then go to DONE when cur=NUM_DEV-1; otherwise SHALL increment cur and go to SELECT.
REQ-012 DONE: o_cfg_done=1 for exactly one cycle, then IDLE.
REQ-013 Outside RUN, o_spi_wr_cmd, o_spi_rd_cmd and o_spi_wr_data SHALL be 0 and o_dev_start SHALL be all 0.
REQ-014 In RUN and DRAIN, o_dev_cs_n[cur] SHALL equal i_spi_ncs; all other o_dev_cs_n bits, and all bits in any other state, SHALL be 1.
REQ-015 o_busy SHALL be 1 in SELECT, RUN and DRAIN; o_cur_dev SHALL equal cur, zero-extended.
REQ-016 A start arriving while o_busy=1 SHALL be ignored.
REQ-017 Done inputs from devices other than cur SHALL be ignored.
REQ-018 All devices skipped: SHALL pass through SELECT NUM_DEV cycles, then DONE; o_dev_ok stays 0.

Reset
REQ-019 On nrst=0, all state SHALL clear asynchronously: FSM=IDLE, cur=0, start edge register=0, o_dev_ok=0, o_dev_err=0, timeout counter=0, o_cfg_done=0, o_busy=0, o_dev_cs_n all 1.
REQ-020 Reset asserted mid-sequence SHALL abort the sequence with no o_cfg_done pulse.

Configuration
REQ-021 Macro SPI_CFG_TIMEOUT_EN defined: a counter SHALL clear on RUN entry and increment each RUN cycle. When it reaches TIMEOUT_CYCLES-1 without done, SHALL set o_dev_err[cur] and go to DRAIN. Done and timeout in the same cycle: done wins and o_dev_err stays 0.
REQ-022 Macro SPI_CFG_TIMEOUT_EN undefined: no counter SHALL be instantiated; o_dev_err SHALL be constant 0; RUN waits for done indefinitely.

Verification
REQ-023 NUM_DEV=3, skip=000, each engine asserts done 50 cycles after start -> devices run 0,1,2 in order; o_dev_ok=111; one o_cfg_done pulse.
REQ-024 skip=001 -> device 0 never gets o_dev_start and o_dev_cs_n[0] stays 1; o_dev_ok=110.
REQ-025 skip=111 -> o_cfg_done pulses 5 cycles after start edge; o_dev_ok=000.
REQ-026 SPI_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=100, device 1 never done -> o_dev_err=010 after 100 RUN cycles; device 2 still runs; o_dev_ok=101.
REQ-027 Done asserted with i_spi_busy=1 for 20 cycles -> cur advances only after busy falls; i_spi_ncs toggling reaches only o_dev_cs_n[cur].
REQ-028 nrst pulsed low mid-RUN of device 1; second start edge while busy -> immediate IDLE, all cs_n=1, no done pulse; the second start is ignored.
